// File: rtl/ctrl_param_seq_pkg.sv
// Shared types and constants for the layer parameter sequencer: field map,
// FSM states, per-layer entry layout and count-to-terminal helpers.
package ctrl_param_seq_pkg;

    localparam int NB_LAYERS_D = 4;
    localparam int NB_LOOPS_D  = 5;
    localparam int CFG_W_D     = 16;

    localparam int CLOG2K = 4;
    localparam int CLOG2W = 5;
    localparam int CLOG2L = 4;

    localparam int FLD_KSI = 0;
    localparam int FLD_CKG = 1;
    localparam int FLD_L0  = 2;
    localparam int FLD_OPC = FLD_L0 + NB_LOOPS_D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_RUN,
        ST_DONE
    } state_t;

    // Field order matches {opcode, arv_KSI, arv_CKG, arv_L} on the top ports.
    typedef struct packed {
        logic                                 opc;
        logic [CLOG2K-1:0]                    ksi;
        logic [CLOG2W-1:0]                    ckg;
        logic [NB_LOOPS_D-1:0][CLOG2L-1:0]    l;
    } layer_cfg_t;

    // Raw count to terminal value, saturating at the all-ones of a w-bit field.
    function automatic logic [CFG_W_D-1:0] to_term(input logic [CFG_W_D-1:0] cnt, input int w);
        logic [CFG_W_D:0] lim;
        lim = (CFG_W_D+1)'(1) << w;
        if (cnt == '0)             return '0;
        else if ({1'b0, cnt} > lim) return CFG_W_D'(lim - 1'b1);
        else                        return cnt - 1'b1;
    endfunction

    function automatic logic cnt_err(input logic [CFG_W_D-1:0] cnt, input int w);
        logic [CFG_W_D:0] lim;
        lim = (CFG_W_D+1)'(1) << w;
        return (cnt == '0) || ({1'b0, cnt} > lim);
    endfunction

endpackage

// File: rtl/ctrl_param_tbl.sv
// Per-layer configuration register file; converts raw counts to terminal
// values on write and flags bad writes (busy, bad field, out-of-range count).
module ctrl_param_tbl
    import ctrl_param_seq_pkg::*;
#(
    parameter int NB_LAYERS = NB_LAYERS_D,
    parameter int NB_LOOPS  = NB_LOOPS_D,
    parameter int CFG_W     = CFG_W_D,
    parameter int LID_W     = $clog2(NB_LAYERS),
    parameter int FLD_W     = $clog2(NB_LOOPS + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             idle,
    input  logic [LID_W-1:0] wr_layer,
    input  logic [FLD_W-1:0] wr_field,
    input  logic [CFG_W-1:0] wr_data,
    input  logic [LID_W-1:0] rd_layer,
    output layer_cfg_t       rd_cfg,
    output logic             wr_err
);

    localparam int LI_W = $clog2(NB_LOOPS);

    layer_cfg_t        tbl [NB_LAYERS];
    logic [31:0]       fidx;
    logic              fld_ok;
    logic              conv_err;
    logic              wr_ok;
    logic [LI_W-1:0]   l_idx;
    logic [CLOG2K-1:0] ksi_term;
    logic [CLOG2W-1:0] ckg_term;
    logic [CLOG2L-1:0] l_term;

    always_comb begin
        fidx     = 32'(wr_field);
        fld_ok   = (fidx <= FLD_OPC);
        l_idx    = LI_W'(fidx - FLD_L0);
        ksi_term = CLOG2K'(to_term(wr_data, CLOG2K));
        ckg_term = CLOG2W'(to_term(wr_data, CLOG2W));
        l_term   = CLOG2L'(to_term(wr_data, CLOG2L));
        if (fidx == FLD_KSI)      conv_err = cnt_err(wr_data, CLOG2K);
        else if (fidx == FLD_CKG) conv_err = cnt_err(wr_data, CLOG2W);
        else if (fidx == FLD_OPC) conv_err = 1'b0;
        else                      conv_err = cnt_err(wr_data, CLOG2L);
        // Saturated/zero counts are still stored; only busy or bad-field writes are dropped.
        wr_ok  = we && idle && fld_ok;
        wr_err = we && (!idle || !fld_ok || conv_err);
    end

    assign rd_cfg = tbl[rd_layer];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB_LAYERS; i++) tbl[i] <= '0;
        end else if (wr_ok) begin
            if (fidx == FLD_KSI)      tbl[wr_layer].ksi      <= ksi_term;
            else if (fidx == FLD_CKG) tbl[wr_layer].ckg      <= ckg_term;
            else if (fidx == FLD_OPC) tbl[wr_layer].opc      <= wr_data[0];
            else                      tbl[wr_layer].l[l_idx] <= l_term;
        end
    end

endmodule

// File: rtl/ctrl_param_seq.sv
// Layer parameter sequencer: walks the config table and hands each layer's
// terminal values to the loop-nest controller. CTRL_PARAM_PREFETCH_EN adds a
// shadow entry so non-first layers skip the LOAD cycle.
module ctrl_param_seq
    import ctrl_param_seq_pkg::*;
#(
    parameter int NB_LAYERS = NB_LAYERS_D,
    parameter int NB_LOOPS  = NB_LOOPS_D,
    parameter int CFG_W     = CFG_W_D,
    parameter int LID_W     = $clog2(NB_LAYERS),
    parameter int FLD_W     = $clog2(NB_LOOPS + 3)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [LID_W-1:0]                 cfg_layer,
    input  logic [FLD_W-1:0]                 cfg_field,
    input  logic [CFG_W-1:0]                 cfg_wdata,
    input  logic [LID_W:0]                   nb_layers,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             param_valid,
    input  logic                             param_ready,
    input  logic                             layer_done,
    output logic                             all_done,
    output logic [LID_W-1:0]                 cur_layer,
    output logic                             opcode,
    output logic [CLOG2K-1:0]                arv_KSI,
    output logic [CLOG2W-1:0]                arv_CKG,
    output logic [NB_LOOPS-1:0][CLOG2L-1:0]  arv_L,
    output logic                             cfg_err
);

    localparam logic [LID_W:0] NB_MAX = (LID_W+1)'(NB_LAYERS);

    state_t           state;
    logic [LID_W:0]   nb_q;
    layer_cfg_t       rd_cfg;
    logic [LID_W-1:0] rd_layer;
    logic             tbl_err;
    logic             last;

`ifdef CTRL_PARAM_PREFETCH_EN
    layer_cfg_t shadow;
    // While a layer is in flight the single read port looks one layer ahead.
    assign rd_layer = (state == ST_PRESENT || state == ST_RUN) ? cur_layer + 1'b1 : cur_layer;
`else
    assign rd_layer = cur_layer;
`endif

    assign last = ({1'b0, cur_layer} == nb_q - 1'b1);

    ctrl_param_tbl #(
        .NB_LAYERS(NB_LAYERS), .NB_LOOPS(NB_LOOPS), .CFG_W(CFG_W),
        .LID_W(LID_W), .FLD_W(FLD_W)
    ) u_tbl (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we),
        .idle    (state == ST_IDLE),
        .wr_layer(cfg_layer),
        .wr_field(cfg_field),
        .wr_data (cfg_wdata),
        .rd_layer(rd_layer),
        .rd_cfg  (rd_cfg),
        .wr_err  (tbl_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            nb_q        <= '0;
            busy        <= 1'b0;
            param_valid <= 1'b0;
            all_done    <= 1'b0;
            cur_layer   <= '0;
            {opcode, arv_KSI, arv_CKG, arv_L} <= '0;
            cfg_err     <= 1'b0;
`ifdef CTRL_PARAM_PREFETCH_EN
            shadow      <= '0;
`endif
        end else begin
            if (tbl_err) cfg_err <= 1'b1;
`ifdef CTRL_PARAM_PREFETCH_EN
            if (state == ST_PRESENT || state == ST_RUN) shadow <= rd_cfg;
`endif
            if (abort && state != ST_IDLE) begin
                state       <= ST_IDLE;
                busy        <= 1'b0;
                param_valid <= 1'b0;
                all_done    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        busy      <= 1'b1;
                        cur_layer <= '0;
                        if (nb_layers == '0) begin
                            all_done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            nb_q  <= (nb_layers > NB_MAX) ? NB_MAX : nb_layers;
                            state <= ST_LOAD;
                            if (nb_layers > NB_MAX) cfg_err <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        {opcode, arv_KSI, arv_CKG, arv_L} <= rd_cfg;
                        param_valid <= 1'b1;
                        state       <= ST_PRESENT;
                    end
                    ST_PRESENT: if (param_ready) begin
                        param_valid <= 1'b0;
                        state       <= ST_RUN;
                    end
                    ST_RUN: if (layer_done) begin
                        if (last) begin
                            all_done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            cur_layer <= cur_layer + 1'b1;
`ifdef CTRL_PARAM_PREFETCH_EN
                            {opcode, arv_KSI, arv_CKG, arv_L} <= shadow;
                            param_valid <= 1'b1;
                            state       <= ST_PRESENT;
`else
                            state       <= ST_LOAD;
`endif
                        end
                    end
                    ST_DONE: begin
                        all_done <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ctrl_param_seq.sv
// Directed bench for ctrl_param_seq with a raw-count table model and a
// per-cycle compare process on the presented parameters and cfg_err.
module tb_ctrl_param_seq;
    import ctrl_param_seq_pkg::*;

    localparam int NBL = 4;
    localparam int NLP = 5;
    localparam int CW  = 16;
    localparam int LW  = 2;
    localparam int FW  = 3;
`ifdef CTRL_PARAM_PREFETCH_EN
    localparam int LD_LAT = 0;
`else
    localparam int LD_LAT = 1;
`endif

    logic clk, rst_n, cfg_we, start, abort, param_ready, layer_done;
    logic [LW-1:0] cfg_layer;
    logic [FW-1:0] cfg_field;
    logic [CW-1:0] cfg_wdata;
    logic [LW:0]   nb_layers;
    logic busy, param_valid, all_done, opcode, cfg_err;
    logic [LW-1:0] cur_layer;
    logic [CLOG2K-1:0] arv_KSI;
    logic [CLOG2W-1:0] arv_CKG;
    logic [NLP-1:0][CLOG2L-1:0] arv_L;

    ctrl_param_seq #(.NB_LAYERS(NBL), .NB_LOOPS(NLP), .CFG_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .nb_layers(nb_layers),
        .start(start), .abort(abort), .busy(busy), .param_valid(param_valid),
        .param_ready(param_ready), .layer_done(layer_done), .all_done(all_done),
        .cur_layer(cur_layer), .opcode(opcode), .arv_KSI(arv_KSI),
        .arv_CKG(arv_CKG), .arv_L(arv_L), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int raw [NBL][NLP+3];
    bit m_err = 0;
    bit chk_en = 0;
    int exp_layer = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int fw(input int f);
        if (f == 0) return CLOG2K;
        if (f == 1) return CLOG2W;
        return CLOG2L;
    endfunction

    function automatic int term(input int c, input int w);
        if (c == 0) return 0;
        if (c > (1 << w)) return (1 << w) - 1;
        return c - 1;
    endfunction

    function automatic int expf(input int l, input int f);
        if (f == NLP + 2) return raw[l][f] & 1;
        return term(raw[l][f], fw(f));
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("cfg_err", cfg_err, m_err);
            if (param_valid) begin
                chk("m_layer", cur_layer, exp_layer);
                chk("m_ksi", arv_KSI, expf(exp_layer, 0));
                chk("m_ckg", arv_CKG, expf(exp_layer, 1));
                chk("m_opc", opcode, expf(exp_layer, NLP + 2));
                for (int i = 0; i < NLP; i++) chk("m_loop", arv_L[i], expf(exp_layer, 2 + i));
            end
            if (all_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int l, input int f, input int d, input bit idle);
        cfg_we = 1'b1; cfg_layer = LW'(l); cfg_field = FW'(f); cfg_wdata = CW'(d);
        tick();
        cfg_we = 1'b0;
        if (!idle) m_err = 1;
        else begin
            raw[l][f] = d;
            if (f < NLP + 2 && (d == 0 || d > (1 << fw(f)))) m_err = 1;
        end
    endtask

    task automatic start_seq(input int n);
        nb_layers = (LW+1)'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pv(output int n);
        n = 0;
        while (param_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk("pv_seen", param_valid, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pv"}, param_valid, 0);
        chk({tag, "_done"}, all_done, 0);
        chk({tag, "_layer"}, cur_layer, 0);
        chk({tag, "_opc"}, opcode, 0);
        chk({tag, "_ksi"}, arv_KSI, 0);
        chk({tag, "_ckg"}, arv_CKG, 0);
        chk({tag, "_L"}, arv_L, 0);
        chk({tag, "_err"}, cfg_err, 0);
    endtask

    task automatic clear_model();
        for (int l = 0; l < NBL; l++)
            for (int f = 0; f < NLP + 3; f++) raw[l][f] = 0;
        m_err = 0;
    endtask

    task automatic run_layers(input int n_req, input int n_eff, input int dly_layer);
        int n;
        start_seq(n_req);
        if (n_req > NBL) m_err = 1;
        for (int l = 0; l < n_eff; l++) begin
            exp_layer = l;
            wait_pv(n);
            chk("pv_latency", n, (l == 0) ? 1 : LD_LAT);
            chk("cur_layer", cur_layer, l);
            if (l == dly_layer) repeat (5) begin tick(); chk("pv_hold", param_valid, 1); end
            param_ready = 1'b1; tick(); param_ready = 1'b0;
            chk("pv_drop", param_valid, 0);
            layer_done = 1'b1; tick(); layer_done = 1'b0;
        end
        chk("all_done", all_done, 1);
        tick();
        chk("busy_end", busy, 0);
        chk("done_end", all_done, 0);
    endtask

    task automatic do_reset();
        chk_en = 0; rst_n = 1'b0;
        #1;
        chk_zero("rst");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1;
    endtask

    initial begin
        int n, dc;
        int l1 [NLP+3];
        int l2 [NLP+3];
        l1 = '{7, 20, 6, 1, 16, 2, 9, 0};
        l2 = '{16, 32, 1, 1, 1, 1, 1, 1};
        rst_n = 1'b0; cfg_we = 0; start = 0; abort = 0; param_ready = 0; layer_done = 0;
        cfg_layer = '0; cfg_field = '0; cfg_wdata = '0; nb_layers = '0;
        clear_model();
        #3 chk_zero("por");
        @(negedge clk); rst_n = 1'b1;
        tick(); chk_en = 1;

        // single layer, literal expectations
        wr(0, 0, 3, 1); wr(0, 1, 4, 1);
        for (int i = 0; i < NLP; i++) wr(0, 2 + i, i + 1, 1);
        wr(0, NLP + 2, 1, 1);
        exp_layer = 0; param_ready = 1'b1;
        start_seq(1);
        chk("load_pv", param_valid, 0);
        wait_pv(n);
        chk("start_lat", n, 1);
        chk("lit_ksi", arv_KSI, 2);
        chk("lit_ckg", arv_CKG, 3);
        chk("lit_L", arv_L, 32'h43210);
        chk("lit_opc", opcode, 1);
        tick(); param_ready = 1'b0;
        chk("run_pv", param_valid, 0);
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        chk("done_pulse", all_done, 1);
        chk("done_busy", busy, 1);
        tick();
        chk("done_low", all_done, 0);
        chk("idle_busy", busy, 0);
        chk("done_cnt1", done_cnt, 1);
        chk("idle_hold_ksi", arv_KSI, 2);

        // three layers, stall on layer 1
        for (int f = 0; f < NLP + 3; f++) begin wr(1, f, l1[f], 1); wr(2, f, l2[f], 1); end
        chk("no_err_yet", cfg_err, 0);
        run_layers(3, 3, 1);

        // zero and oversized counts
        wr(0, 2, 0, 1); wr(0, 3, (1 << CLOG2L) + 7, 1);
        exp_layer = 0;
        start_seq(1);
        wait_pv(n);
        chk("sat_zero", arv_L[0], 0);
        chk("sat_ones", arv_L[1], 15);
        chk("err_set", cfg_err, 1);
        param_ready = 1'b1; tick(); param_ready = 1'b0;
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        tick();

        // abort in PRESENT beats param_ready
        start_seq(2); exp_layer = 0;
        wait_pv(n);
        abort = 1'b1; param_ready = 1'b1; tick(); abort = 1'b0; param_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pv", param_valid, 0);
        dc = done_cnt;
        repeat (3) tick();
        chk("abort_nodone", done_cnt, dc);
        chk("err_sticky", cfg_err, 1);
        run_layers(1, 1, -1);

        // empty sequence
        start_seq(0);
        chk("nb0_done", all_done, 1);
        chk("nb0_busy", busy, 1);
        chk("nb0_pv", param_valid, 0);
        tick();
        chk("nb0_end", all_done, 0);
        chk("nb0_idle", busy, 0);

        // async reset mid-RUN
        start_seq(1); exp_layer = 0;
        wait_pv(n);
        param_ready = 1'b1; tick(); param_ready = 1'b0;
        do_reset();
        run_layers(1, 1, -1);

        // ignored inputs while busy
        wr(1, 0, 7, 1);
        start_seq(2); exp_layer = 0;
        wait_pv(n);
        start = 1'b1; nb_layers = 3'd1; layer_done = 1'b1;
        tick();
        start = 1'b0; layer_done = 1'b0;
        chk("ign_pv", param_valid, 1);
        chk("ign_layer", cur_layer, 0);
        param_ready = 1'b1; tick(); param_ready = 1'b0;
        wr(1, 0, 9, 0);
        chk("busy_wr_err", cfg_err, 1);
        exp_layer = 1;
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        wait_pv(n);
        chk("next_lat", n, LD_LAT);
        chk("tbl_kept", arv_KSI, 6);
        param_ready = 1'b1; tick(); param_ready = 1'b0;
        layer_done = 1'b1; tick(); layer_done = 1'b0;
        chk("busy_seq_done", all_done, 1);
        tick();

        // nb_layers above table size is clamped
        do_reset();
        run_layers(6, NBL, -1);
        chk("clamp_err", cfg_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_param_seq.md
Name: ctrl_param_seq

Overview:
Parametrised, sequential successor to the fixed two-mode loop-bound generator.
- Holds a per-layer configuration table of NB_LAYERS entries, each with KSI, CKG, NB_LOOPS loop counts and an opcode bit.
- On start, walks layers 0..nb_layers-1 and presents each layer's terminal values (count-1) to the loop-nest controller over a valid/ready handshake.
- Waits for layer_done before advancing to the next layer.
- Sits between the host config interface and the NPU loop counters.

Parameters:
NB_LAYERS, 4, number of layer entries in the table
NB_LOOPS, 5, number of loop bounds L0..L(NB_LOOPS-1) per layer
CFG_W, 16, width of cfg_wdata (raw counts)
LID_W, $clog2(NB_LAYERS), layer index width
FLD_W, $clog2(NB_LOOPS+3), field select width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_layer  in  LID_W  layer entry written
cfg_field  in  FLD_W  0=KSI, 1=CKG, 2..NB_LOOPS+1=L0.., NB_LOOPS+2=opcode
cfg_wdata  in  CFG_W  raw count; bit0 only for the opcode field
nb_layers  in  LID_W+1  layers to run, sampled on start
start  in  1  start pulse
abort  in  1  synchronous abort
busy  out  1  sequence active
param_valid  out  1  current layer parameters valid
param_ready  in  1  consumer accepts parameters
layer_done  in  1  consumer finished the current layer
all_done  out  1  one-cycle pulse at end of sequence
cur_layer  out  LID_W  index of the presented layer
opcode  out  1  layer opcode
arv_KSI  out  CLOG2K  KSI terminal value
arv_CKG  out  CLOG2W  CKG terminal value
arv_L  out  NB_LOOPS x CLOG2L  loop terminal values, packed
cfg_err  out  1  sticky configuration error

Behaviour:
- Reset: all outputs 0, FSM IDLE, table cleared to 0.
- Terminal conversion happens at table write and is stored at field width:
  - count 0 stores terminal 0 and sets cfg_err.
  - count > 2^width stores all-ones and sets cfg_err.
  - Otherwise stores count-1.
- cfg_err clears only on reset.
- Writes are accepted only in IDLE. A write while busy is dropped and sets cfg_err.
- A field index above NB_LOOPS+2 is dropped and sets cfg_err.
- FSM states:
  - IDLE: start with nb_layers=0 goes to DONE. start with nb_layers>nb_layers-max (NB_LAYERS) is clamped to NB_LAYERS and sets cfg_err. Otherwise latch the count, cur_layer=0, go to LOAD.
  - LOAD: one cycle; copy table[cur_layer] into the output registers; go to PRESENT.
  - PRESENT: param_valid=1 and outputs stable until param_ready is seen; then go to RUN with param_valid=0 next cycle.
  - RUN: layer_done on the last layer goes to DONE. Otherwise cur_layer++ and go to LOAD.
  - DONE: all_done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Outputs hold the last presented values in IDLE.
- Latency: start in cycle t gives param_valid in t+2. layer_done in t gives the next param_valid in t+2.
- Ignored inputs:
  - start while busy.
  - layer_done outside RUN.
  - param_ready while param_valid=0.
- A cfg_we and start in the same IDLE cycle both take effect; LOAD sees the new value.
- abort in any non-IDLE state: IDLE next cycle, param_valid=0, all_done not pulsed, table preserved. abort has priority over layer_done and param_ready.
- Asynchronous reset mid-sequence: immediate return to reset state.

Optional Feature:
Macro CTRL_PARAM_PREFETCH_EN.
- Defined:
  - A shadow register loads table[cur_layer+1] during RUN.
  - On non-final layer_done, the FSM skips LOAD and goes directly to PRESENT.
  - Next param_valid arrives at t+1.
  - The first layer still passes through LOAD.
- Undefined: no shadow register; latency as above.

Decomposition:
- In globals_sv:
  - CLOG2K/CLOG2W/CLOG2L (already present).
  - Field-index localparams FLD_KSI, FLD_CKG, FLD_L0, FLD_OPC.
  - State enum typedef.
  - Packed struct typedef layer_cfg_t holding opcode, KSI, CKG and the L array.
- One natural sub-module: ctrl_param_tbl, holding the register-file table plus saturating count-to-terminal conversion and error flags.
- The FSM stays in the top module.

Test Plan:
- Write layer0 KSI=3, CKG=4, L0..L4=1,2,3,4,5, opcode=1; nb_layers=1; start; param_ready held high -> param_valid at t+2 with arv_KSI=2, arv_CKG=3, arv_L=0,1,2,3,4, opcode=1; after layer_done, all_done pulses exactly once and busy drops.
- Three layers with param_ready delayed 5 cycles on layer1 -> outputs stable while waiting; cur_layer sequence 0,1,2; each next param_valid appears 2 cycles after layer_done (1 cycle with CTRL_PARAM_PREFETCH_EN).
- Write count 0 and count 2^CLOG2L+7 -> stored terminals 0 and all-ones; cfg_err=1 and stays set until reset.
- cfg_we during RUN, start while busy, layer_done in PRESENT -> table unchanged, cfg_err set by the write, sequence unaffected.
- abort in PRESENT -> IDLE next cycle, param_valid=0, no all_done; restart reproduces the same layer0 values.
- nb_layers=0 -> all_done one cycle after start, param_valid never asserted; rst_n low mid-RUN -> all outputs 0 immediately.
